// File: rtl/jpeg_bitbuffer_param.sv
// Entropy-stream bit buffer: byte-wide input with optional JPEG unstuffing and
// marker extraction, MSB-first variable-consume window toward the Huffman decoder.
module jpeg_bitbuffer_param #(
    parameter int DEPTH_BYTES  = 8,
    parameter int OUT_W        = 32,
    parameter bit STUFF_REMOVE = 1'b1,
    parameter int CW           = $clog2(OUT_W + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 img_start_i,
    input  logic                                 inport_valid_i,
    input  logic [7:0]                           inport_data_i,
    input  logic                                 inport_last_i,
    output logic                                 ready_o,
    input  logic [CW-1:0]                        yumi_i,
    output logic                                 v_o,
    output logic [OUT_W-1:0]                     outport_data_o,
    output logic                                 outport_last_o,
    output logic [$clog2(8*DEPTH_BYTES+1)-1:0]   level_o,
    output logic                                 marker_v_o,
    output logic [7:0]                           marker_code_o
);

    localparam int CAP = 8 * DEPTH_BYTES;
    localparam int LW  = $clog2(CAP + 1);
    localparam int BW  = $clog2(CAP);
    localparam int AW  = $clog2(DEPTH_BYTES);

    // Handshake: a byte transfers on a rising edge where inport_valid_i and
    // ready_o are both high; ready_o depends on registered state only.
    // The decoder consumes yumi_i bits on any edge where v_o is high.

    logic [7:0]    mem_q [DEPTH_BYTES];
    logic [AW-1:0] wr_ptr_q;
    logic [BW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          drain_q;
    logic          ff_pend_q;
    logic          marker_v_q;
    logic [7:0]    marker_code_q;

    logic          accept;
    logic          push;
    logic [7:0]    push_byte;
    logic          ff_pend_d;
    logic          marker_hit;
    logic          drain_d;
    logic [LW-1:0] yumi_ext;
    logic [LW-1:0] pop;
    logic [LW-1:0] count_d;
    logic [BW-1:0] rd_ptr_d;

    assign ready_o        = !drain_q && (count_q <= LW'(CAP - 8));
    assign v_o            = (count_q >= LW'(OUT_W)) || (drain_q && (count_q != '0));
    assign outport_last_o = drain_q && (count_q != '0) && (count_q <= LW'(OUT_W));
    assign level_o        = count_q;
    assign marker_v_o     = marker_v_q;
    assign marker_code_o  = marker_code_q;

    // A byte offered together with img_start_i is dropped.
    assign accept = inport_valid_i && ready_o && !img_start_i;

    always_comb begin
        push       = 1'b0;
        push_byte  = inport_data_i;
        ff_pend_d  = ff_pend_q;
        marker_hit = 1'b0;
        if (accept) begin
            if (STUFF_REMOVE) begin
                if (!ff_pend_q) begin
                    if (inport_data_i == 8'hFF) begin
                        ff_pend_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else if (inport_data_i == 8'h00) begin
                    push      = 1'b1;
                    push_byte = 8'hFF;
                    ff_pend_d = 1'b0;
                end else if (inport_data_i == 8'hFF) begin
                    ff_pend_d = 1'b1;
                end else begin
                    marker_hit = 1'b1;
                    ff_pend_d  = 1'b0;
                end
            end else begin
                push = 1'b1;
            end
            // A dangling 0xFF at end of image is discarded.
            if (inport_last_i) begin
                ff_pend_d = 1'b0;
            end
        end
    end

    assign drain_d = drain_q
                   || (accept && inport_last_i)
                   || (marker_hit && (inport_data_i == 8'hD9));

    // Clamp consumption to the bits held; only reachable during drain.
    assign yumi_ext = LW'(yumi_i);
    assign pop      = v_o ? ((yumi_ext < count_q) ? yumi_ext : count_q) : '0;
    assign count_d  = count_q + (push ? LW'(8) : LW'(0)) - pop;
    assign rd_ptr_d = rd_ptr_q + BW'(pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || img_start_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            drain_q       <= 1'b0;
            ff_pend_q     <= 1'b0;
            marker_v_q    <= 1'b0;
            marker_code_q <= 8'h00;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            drain_q    <= drain_d;
            ff_pend_q  <= ff_pend_d;
            marker_v_q <= marker_hit;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (marker_hit) begin
                marker_code_q <= inport_data_i;
            end
        end
    end

    // Storage needs no reset: unread positions are masked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    // Window bit i is stream bit rd_ptr+i; bytes are stored MSB first.
    always_comb begin
        outport_data_o = '1;
        for (int i = 0; i < OUT_W; i++) begin
            logic [BW-1:0] idx;
            idx = rd_ptr_q + BW'(i);
            if (LW'(i) < count_q) begin
                outport_data_o[OUT_W-1-i] = mem_q[idx[BW-1:3]][3'd7 - idx[2:0]];
            end
        end
    end

    a_yumi_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        v_o |-> (yumi_i <= CW'(OUT_W)));

endmodule

// File: tb/tb_jpeg_bitbuffer_param.sv
// Directed and randomised checks of jpeg_bitbuffer_param at default parameters.
module tb_jpeg_bitbuffer_param;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        img_start_i = 1'b0;
  logic        inport_valid_i = 1'b0;
  logic [7:0]  inport_data_i = 8'h00;
  logic        inport_last_i = 1'b0;
  logic        ready_o;
  logic [5:0]  yumi_i = 6'd0;
  logic        v_o;
  logic [31:0] outport_data_o;
  logic        outport_last_o;
  logic [6:0]  level_o;
  logic        marker_v_o;
  logic [7:0]  marker_code_o;

  int checks = 0;
  int errors = 0;
  int marker_cnt = 0;
  logic [0:0] exp_q[$];

  jpeg_bitbuffer_param dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .img_start_i    (img_start_i),
    .inport_valid_i (inport_valid_i),
    .inport_data_i  (inport_data_i),
    .inport_last_i  (inport_last_i),
    .ready_o        (ready_o),
    .yumi_i         (yumi_i),
    .v_o            (v_o),
    .outport_data_o (outport_data_o),
    .outport_last_o (outport_last_o),
    .level_o        (level_o),
    .marker_v_o     (marker_v_o),
    .marker_code_o  (marker_code_o)
  );

  // clock / reset / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk_i) if (marker_v_o === 1'b1) marker_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: all driving happens just after a falling edge
  task automatic push_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (ready_o !== 1'b1) check("push_ready_timeout", ready_o, 1'b1);
    inport_valid_i = 1'b1;
    inport_data_i  = b;
    inport_last_i  = last;
    @(negedge clk_i);
    inport_valid_i = 1'b0;
    inport_last_i  = 1'b0;
  endtask

  task automatic consume(input int n);
    yumi_i = 6'(n);
    @(negedge clk_i);
    yumi_i = 6'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic clear_buf();
    img_start_i = 1'b1;
    @(negedge clk_i);
    img_start_i = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, ready_o, 1'b1);
    check({tag, "_v"}, v_o, 1'b0);
    check({tag, "_last"}, outport_last_o, 1'b0);
    check({tag, "_mv"}, marker_v_o, 1'b0);
    check({tag, "_mcode"}, marker_code_o, 8'h00);
    check({tag, "_data"}, outport_data_o, 32'hFFFF_FFFF);
    check({tag, "_level"}, level_o, 7'd0);
  endtask

  initial begin
    int mk0;
    idle(3);
    rst_ni = 1'b1;
    idle(1);
    check_reset("rst");

    // basic fill and consume
    push_byte(8'h12, 1'b0);
    push_byte(8'h34, 1'b0);
    push_byte(8'h56, 1'b0);
    check("basic_v_24", v_o, 1'b0);
    push_byte(8'h78, 1'b0);
    check("basic_v", v_o, 1'b1);
    check("basic_data", outport_data_o, 32'h1234_5678);
    check("basic_level", level_o, 7'd32);
    consume(4);
    check("basic_v28", v_o, 1'b0);
    check("basic_level28", level_o, 7'd28);
    check("basic_pad28", outport_data_o, 32'h2345_678F);
    push_byte(8'h10, 1'b0);
    check("basic_data36", outport_data_o, 32'h2345_6781);
    check("basic_level36", level_o, 7'd36);
    clear_buf();
    check_reset("clr1");

    // stuffing
    mk0 = marker_cnt;
    push_byte(8'hFF, 1'b0);
    push_byte(8'h00, 1'b0);
    push_byte(8'hAB, 1'b0);
    push_byte(8'hFF, 1'b0);
    push_byte(8'hFF, 1'b0);
    push_byte(8'h00, 1'b0);
    push_byte(8'hCD, 1'b0);
    check("stuff_level", level_o, 7'd32);
    check("stuff_data", outport_data_o, 32'hFFAB_FFCD);
    idle(1);
    check("stuff_no_marker", marker_cnt - mk0, 0);

    // marker mid-stream
    push_byte(8'hFF, 1'b0);
    push_byte(8'hD3, 1'b0);
    check("mk_pulse", marker_v_o, 1'b1);
    check("mk_code", marker_code_o, 8'hD3);
    check("mk_level", level_o, 7'd32);
    idle(1);
    check("mk_pulse_end", marker_v_o, 1'b0);
    check("mk_code_hold", marker_code_o, 8'hD3);
    check("mk_data", outport_data_o, 32'hFFAB_FFCD);
    clear_buf();
    check_reset("clr2");

    // drain and pad
    push_byte(8'hA5, 1'b1);
    check("drn_v", v_o, 1'b1);
    check("drn_last", outport_last_o, 1'b1);
    check("drn_data", outport_data_o, 32'hA5FF_FFFF);
    check("drn_ready", ready_o, 1'b0);
    check("drn_level", level_o, 7'd8);
    consume(32);
    check("drn_level0", level_o, 7'd0);
    check("drn_v0", v_o, 1'b0);
    check("drn_last0", outport_last_o, 1'b0);
    check("drn_data0", outport_data_o, 32'hFFFF_FFFF);
    idle(3);
    check("drn_ready_stay", ready_o, 1'b0);
    check("drn_v_stay", v_o, 1'b0);
    clear_buf();
    check_reset("clr3");

    // EOI marker starts drain
    push_byte(8'h11, 1'b0);
    push_byte(8'hFF, 1'b0);
    push_byte(8'hD9, 1'b0);
    check("eoi_pulse", marker_v_o, 1'b1);
    check("eoi_code", marker_code_o, 8'hD9);
    check("eoi_ready", ready_o, 1'b0);
    check("eoi_level", level_o, 7'd8);
    check("eoi_v", v_o, 1'b1);
    check("eoi_last", outport_last_o, 1'b1);
    check("eoi_data", outport_data_o, 32'h11FF_FFFF);
    clear_buf();
    check_reset("clr4");

    // full boundary
    for (int i = 1; i <= 7; i++) push_byte(8'(i), 1'b0);
    check("full_level56", level_o, 7'd56);
    check("full_ready56", ready_o, 1'b1);
    push_byte(8'h08, 1'b0);
    check("full_level64", level_o, 7'd64);
    check("full_ready64", ready_o, 1'b0);
    check("full_data", outport_data_o, 32'h0102_0304);
    consume(32);
    check("full_level32", level_o, 7'd32);
    check("full_ready32", ready_o, 1'b1);
    check("full_data2", outport_data_o, 32'h0506_0708);

    // mid-stream clear with pending 0xFF and a byte in the clear cycle
    clear_buf();
    for (int i = 0; i < 5; i++) push_byte(8'hA1 + 8'(i), 1'b0);
    push_byte(8'hFF, 1'b0);
    check("mid_level40", level_o, 7'd40);
    img_start_i    = 1'b1;
    inport_valid_i = 1'b1;
    inport_data_i  = 8'h55;
    @(negedge clk_i);
    img_start_i    = 1'b0;
    inport_valid_i = 1'b0;
    check_reset("mid_clr");
    push_byte(8'h00, 1'b0);
    check("mid_pend_clr_data", outport_data_o, 32'h00FF_FFFF);
    check("mid_pend_clr_level", level_o, 7'd8);

    // same with reset
    clear_buf();
    for (int i = 0; i < 5; i++) push_byte(8'hB1 + 8'(i), 1'b0);
    push_byte(8'hFF, 1'b0);
    check("rmid_level40", level_o, 7'd40);
    rst_ni         = 1'b0;
    inport_valid_i = 1'b1;
    inport_data_i  = 8'h55;
    @(negedge clk_i);
    rst_ni         = 1'b1;
    inport_valid_i = 1'b0;
    check_reset("rmid_rst");
    push_byte(8'h00, 1'b0);
    check("rmid_pend_clr_data", outport_data_o, 32'h00FF_FFFF);
    check("rmid_pend_clr_level", level_o, 7'd8);

    // random push/consume against a reference bit queue
    clear_buf();
    exp_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int sz;
      int y;
      logic m_v;
      logic m_rdy;
      logic do_push;
      logic [7:0] b;
      logic [31:0] w;
      sz    = exp_q.size();
      m_v   = (sz >= 32);
      m_rdy = (sz <= 56);
      check("rnd_level", level_o, sz);
      check("rnd_v", v_o, m_v);
      check("rnd_ready", ready_o, m_rdy);
      if (m_v) begin
        for (int i = 0; i < 32; i++) w[31-i] = exp_q[i];
        check("rnd_data", outport_data_o, w);
      end
      do_push = m_rdy && ($urandom_range(0, 3) != 0);
      b = 8'($urandom_range(0, 254));
      y = m_v ? int'($urandom_range(1, 32)) : 0;
      inport_valid_i = do_push;
      inport_data_i  = b;
      yumi_i         = 6'(y);
      for (int i = 0; i < y; i++) void'(exp_q.pop_front());
      if (do_push) for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
      @(negedge clk_i);
    end
    inport_valid_i = 1'b0;
    yumi_i         = 6'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_bitbuffer_param.md
# jpeg_bitbuffer_param

Parametrised entropy-stream bit buffer between the JPEG byte input (file parser) and the Huffman decoder. It accepts one byte per cycle and, optionally, removes JPEG byte stuffing and detects markers in-line. It presents an MSB-first window of `OUT_W` bits from which the decoder consumes a variable number of bits per cycle. During end-of-image drain it signals the final window and pads beyond the valid bits with ones.

## Interface
Parameters:
- `DEPTH_BYTES`, 8: storage depth in bytes. Power of two, ≥ 4.
- `OUT_W`, 32: output window width in bits. Must satisfy 8 ≤ `OUT_W` ≤ 8·(`DEPTH_BYTES`−1).
- `STUFF_REMOVE`, 1:
  - 1: strip 0x00 after 0xFF and extract markers.
  - 0: pass bytes through unmodified.
- `CW`, $clog2(`OUT_W`+1): width of `yumi_i`.

Ports:
- `clk_i` in 1: clock. One clock domain.
- `rst_ni` in 1: reset. Synchronous, active-low.
- `img_start_i` in 1: soft clear of all state. Same effect as reset.
- `inport_valid_i` in 1: input byte valid.
- `inport_data_i` in 8: input byte.
- `inport_last_i` in 1: final byte of the image. Qualified by valid && ready.
- `ready_o` out 1: input byte accepted this cycle when high.
- `yumi_i` in `CW`: number of bits consumed. Honoured only when `v_o` is high.
- `v_o` out 1: output window valid.
- `outport_data_o` out `OUT_W`: next bits, MSB = oldest bit.
- `outport_last_o` out 1: window holds all remaining bits of the image.
- `level_o` out $clog2(8·`DEPTH_BYTES`+1): valid bit count.
- `marker_v_o` out 1: one-cycle pulse, marker detected.
- `marker_code_o` out 8: second marker byte. Held until the next marker.

## Operation
- Storage: circular array of `DEPTH_BYTES` bytes.
  - `wr_ptr` counts bytes; `rd_ptr` counts bits. Both wrap modulo capacity (CAP = 8·`DEPTH_BYTES`).
  - `count` holds valid bits, range 0..CAP.
- `ready_o` = !drain_q && (count_q ≤ CAP−8).
- Accepted byte handling with `STUFF_REMOVE`=1 (the `ff_pend` flag is a 1-bit register):
  - ff_pend=0, byte ≠ 0xFF: push byte.
  - ff_pend=0, byte = 0xFF: set ff_pend. Push nothing.
  - ff_pend=1, byte = 0x00: push 0xFF. Clear ff_pend.
  - ff_pend=1, byte = 0xFF: fill byte. Push nothing. ff_pend stays set.
  - ff_pend=1, any other byte: marker. Push nothing. Clear ff_pend. Pulse `marker_v_o`. Load `marker_code_o`.
  - Marker code 0xD9 (EOI) sets drain_q.
  - A pending 0xFF does not occupy storage and is never counted.
- With `STUFF_REMOVE`=0, every accepted byte is pushed and markers never fire.
- Drain: drain_q is set by an accepted byte with `inport_last_i`=1. If ff_pend is set at that point, the 0xFF is discarded.
- Count update: count_next = count_q + 8·push − pop.
  - pop = min(`yumi_i`, count_q) when `v_o` is high, else 0.
  - `yumi_i` > `OUT_W` is illegal (assertion). In drain, over-consumption clamps count to 0.
- `v_o` = (count_q ≥ `OUT_W`) || (drain_q && count_q ≠ 0).
- `outport_data_o`: `OUT_W` bits starting at `rd_ptr`, with wrap-around. Bit positions ≥ count_q read as 1, so count_q = 0 gives all ones.
- `outport_last_o` = drain_q && count_q ≠ 0 && count_q ≤ `OUT_W`.
- After drain empties, `v_o` and `ready_o` stay low until `img_start_i` or reset.
- Priority: reset > `img_start_i` > push/pop. A byte offered in an `img_start_i` cycle is dropped.

## Timing
- Reset or `img_start_i` (registered effect, visible next cycle):
  - count, pointers, drain_q, ff_pend = 0.
  - `ready_o`=1, `v_o`=0, `outport_last_o`=0, `marker_v_o`=0, `marker_code_o`=0x00.
  - `outport_data_o` = all ones, `level_o`=0.
- Push latency: a byte accepted at edge N is reflected in count, `v_o` and data from cycle N+1.
- Pop latency: bits consumed at edge N shift the window at N+1. Back-to-back pops every cycle are allowed.
- `marker_v_o` is registered: it is high for exactly the cycle after the marker byte is accepted.
- Simultaneous push and pop at full boundary:
  - `ready_o` depends on count_q only. There is no combinational path from `yumi_i` to `ready_o`.
  - Data written and read in the same cycle never alias, because ready requires ≥ 8 free bits.
- All outputs are functions of registers only. No input-to-output combinational paths.

## Test plan
- Basic fill and consume, defaults:
  - Stimulus: bytes 0x12,0x34,0x56,0x78; then `yumi_i`=4.
  - Response: `v_o` rises the cycle after the 4th byte with data 0x12345678; next cycle data = 0x2345678F-prefix-free, i.e. 0x23456781 only once a 5th byte 0x1x arrives, otherwise `v_o`=0 (count 28).
- Stuffing:
  - Stimulus: 0xFF,0x00,0xAB,0xFF,0xFF,0x00,0xCD.
  - Response: stored stream 0xFF,0xAB,0xFF,0xCD; `level_o`=32; no `marker_v_o`.
- Markers:
  - Stimulus: 0xFF,0xD3 mid-stream.
  - Response: one-cycle `marker_v_o`, `marker_code_o`=0xD3, level unchanged.
  - Stimulus: 0xFF,0xD9.
  - Response: drain_q set; `ready_o` goes low.
- Drain and pad:
  - Stimulus: 0xA5 with `inport_last_i`=1.
  - Response: `v_o`=1, `outport_last_o`=1, data 0xA5FFFFFF.
  - Stimulus: `yumi_i`=32.
  - Response: count clamps to 0; `v_o`=0; `ready_o` stays low.
- Full and wrap, `DEPTH_BYTES`=8:
  - Stimulus: push 56 bits.
  - Response: `ready_o`=0 at count 64 only; `ready_o` high at count 56.
  - Stimulus: random pushes with `yumi_i` 1..32 for 10k cycles against a reference bit queue.
  - Response: exact data match across pointer wrap.
- Mid-stream clear:
  - Stimulus: `img_start_i` with count=40, ff_pend=1, a byte offered in the same cycle.
  - Response: all outputs at reset values next cycle; the byte is dropped.
  - Repeat the same check with `rst_ni`=0.
